// File: rtl/control_unit.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch/decode/execute
// and decoding the per-state datapath controls.
module control_unit #(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCen,
    output logic       IorD,
    output logic       Ori,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_GPIEX  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_GPI   = 6'h3F;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUO   = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    state_t     state_q, state_d;
    logic       funct_ok_c;
    logic [2:0] funct_alu_c;
    logic       pc_write_c, branch_c, ir_write_c, mem_write_c, reg_write_c;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // R-type funct decode; unsupported functs execute as a NOP
    always_comb begin
        funct_ok_c  = 1'b1;
        funct_alu_c = ALU_ADD;
        case (funct)
            6'h20:   funct_alu_c = ALU_ADD;
            6'h22:   funct_alu_c = ALU_SUB;
            6'h24:   funct_alu_c = ALU_AND;
            6'h25:   funct_alu_c = ALU_OR;
            6'h2A:   funct_alu_c = ALU_SLT;
            default: funct_ok_c  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = S_FETCH;
        pc_write_c  = 1'b0;
        branch_c    = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        IorD        = 1'b0;
        Ori         = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSrc       = PC_ALU;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_BOFS;
                case (op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_BNE:           state_d = BNE_EN ? S_BRANCH : S_FETCH;
                    OP_ADDI, OP_SLTI: state_d = S_IMMEX;
                    OP_J:             state_d = S_JUMP;
                    OP_GPI:           state_d = S_GPIEX;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_c = 1'b1;
            end
            S_MEMWR: begin
                IorD        = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu_c;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst      = 1'b1;
                reg_write_c = funct_ok_c;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = PC_ALUO;
                branch_c   = ((op == OP_BEQ) && zero) ||
                             (BNE_EN && (op == OP_BNE) && !zero);
            end
            S_IMMEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d    = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write_c = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = PC_JUMP;
                pc_write_c = 1'b1;
            end
            S_GPIEX: begin
                Ori     = 1'b1;
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_IMMWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Architectural write enables are held off for as long as reset is low
    assign PCen     = reset & (pc_write_c | branch_c);
    assign IRWrite  = reset & ir_write_c;
    assign MemWrite = reset & mem_write_c;
    assign RegWrite = reset & reg_write_c;
    assign state_o  = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instruction table, reset-abort sequence and
// random instruction stream checked against a per-instruction reference model.
module tb_control_unit;

    localparam bit BNE_EN = 1'b1;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int tests = 0;
    int fails = 0;

    control_unit #(.BNE_EN(BNE_EN)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCen(PCen), .IorD(IorD), .Ori(Ori), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          len;
        logic [23:0] seq;
    } vec_t;

    function automatic logic [15:0] got_vec();
        return {PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                ALUSrcA, ALUSrcB, PCSrc, ALUControl};
    endfunction

    function automatic logic [15:0] mk(logic pcen, logic iord, logic ori, logic mw, logic irw,
                                       logic rd, logic m2r, logic rw, logic sa,
                                       logic [1:0] sb, logic [1:0] ps, logic [2:0] ctl);
        return {pcen, iord, ori, mw, irw, rd, m2r, rw, sa, sb, ps, ctl};
    endfunction

    // Expected control word for each step of an instruction
    function automatic logic [15:0] exp_out(int st, logic [5:0] o, logic [5:0] f, logic z);
        logic [2:0] rctl;
        logic       rok;
        rok  = 1'b1;
        rctl = 3'b010;
        if      (f == 6'h20) rctl = 3'b010;
        else if (f == 6'h22) rctl = 3'b110;
        else if (f == 6'h24) rctl = 3'b000;
        else if (f == 6'h25) rctl = 3'b001;
        else if (f == 6'h2A) rctl = 3'b111;
        else rok = 1'b0;
        case (st)
            0:  return mk(1,0,0,0,1,0,0,0,0,2'b01,2'b00,3'b010);
            1:  return mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
            2:  return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
            3:  return mk(0,1,0,0,0,0,0,0,0,2'b00,2'b00,3'b010);
            4:  return mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b010);
            5:  return mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b010);
            6:  return mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,rctl);
            7:  return mk(0,0,0,0,0,1,0,rok,0,2'b00,2'b00,3'b010);
            8:  return mk((o == 6'h04 && z) || (BNE_EN && o == 6'h05 && !z),
                          0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
            9:  return mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,(o == 6'h0A) ? 3'b111 : 3'b010);
            10: return mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b010);
            11: return mk(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b010);
            12: return mk(0,0,1,0,0,0,0,0,1,2'b10,2'b00,3'b010);
            default: return 16'h0000;
        endcase
    endfunction

    // Step sequence of one instruction, derived from its class
    task automatic model_seq(input logic [5:0] o, output int len, output logic [23:0] seq);
        int q[$];
        q = {0, 1};
        case (o)
            6'h23:        q = {q, 2, 3, 4};
            6'h2B:        q = {q, 2, 5};
            6'h00:        q = {q, 6, 7};
            6'h04:        q.push_back(8);
            6'h05:        if (BNE_EN) q.push_back(8);
            6'h08, 6'h0A: q = {q, 9, 10};
            6'h02:        q.push_back(11);
            6'h3F:        q = {q, 12, 10};
            default:      ;
        endcase
        len = q.size();
        seq = '0;
        foreach (q[i]) seq[i*4 +: 4] = 4'(q[i]);
    endtask

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Enter with the DUT in FETCH, between clock edges; leave likewise
    task automatic run_instr(logic [5:0] o, logic [5:0] f, logic z, int len, logic [23:0] seq);
        int st;
        op = o; funct = f; zero = z;
        #1;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            st = int'(seq[i*4 +: 4]);
            chk($sformatf("state op=%h step%0d", o, i), 16'(state_o), 16'(st));
            chk($sformatf("ctrl op=%h f=%h z=%0d step%0d", o, f, z, i),
                got_vec(), exp_out(st, o, f, z));
        end
        @(posedge clk); #1;
    endtask

    vec_t tbl[12];
    logic [5:0] rops [10];
    logic [5:0] rfns [6];

    initial begin
        tbl[0]  = '{6'h23, 6'h00, 1'b0, 5, 24'h043210};
        tbl[1]  = '{6'h2B, 6'h00, 1'b0, 4, 24'h005210};
        tbl[2]  = '{6'h00, 6'h22, 1'b0, 4, 24'h007610};
        tbl[3]  = '{6'h00, 6'h27, 1'b0, 4, 24'h007610};
        tbl[4]  = '{6'h04, 6'h00, 1'b1, 3, 24'h000810};
        tbl[5]  = '{6'h04, 6'h00, 1'b0, 3, 24'h000810};
        tbl[6]  = '{6'h05, 6'h00, 1'b0, 3, 24'h000810};
        tbl[7]  = '{6'h05, 6'h00, 1'b1, 3, 24'h000810};
        tbl[8]  = '{6'h02, 6'h00, 1'b0, 3, 24'h000B10};
        tbl[9]  = '{6'h08, 6'h00, 1'b0, 4, 24'h00A910};
        tbl[10] = '{6'h3F, 6'h00, 1'b0, 4, 24'h00AC10};
        tbl[11] = '{6'h11, 6'h00, 1'b0, 2, 24'h000010};
        rops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h02, 6'h3F, 6'h11};
        rfns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};

        reset = 1'b0; op = 6'h00; funct = 6'h20; zero = 1'b0;
        #12;
        chk("reset state", 16'(state_o), 16'd0);
        chk("reset ctrl", got_vec(), exp_out(0, op, funct, zero) & 16'h66FF);
        #8 reset = 1'b1;

        foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].len, tbl[i].seq);

        // Reset asserted while a store is writing memory
        op = 6'h2B; funct = 6'h00; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("memwr state", 16'(state_o), 16'd5);
        chk("memwr we", 16'(MemWrite), 16'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort state", 16'(state_o), 16'd0);
        chk("abort ctrl", got_vec(), exp_out(0, op, funct, zero) & 16'h66FF);
        @(posedge clk); #1;
        chk("held state", 16'(state_o), 16'd0);
        chk("held ctrl", got_vec(), exp_out(0, op, funct, zero) & 16'h66FF);
        @(negedge clk);
        reset = 1'b1;
        run_instr(6'h2B, 6'h00, 1'b0, 4, 24'h005210);

        for (int n = 0; n < 60; n++) begin
            logic [5:0]  o, f;
            logic        z;
            int          len;
            logic [23:0] seq;
            o = (n % 7 == 6) ? 6'($urandom) : rops[$urandom_range(9, 0)];
            f = (n % 5 == 4) ? 6'($urandom) : rfns[$urandom_range(5, 0)];
            z = 1'($urandom);
            model_seq(o, len, seq);
            run_instr(o, f, z, len, seq);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: BNE_EN, default 1, 1 enables bne (op 6'h05) decode; 0 treats bne as unsupported.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 op  in  6  opcode, Instr[31:26], from the datapath instruction register.
REQ-006 funct  in  6  function field, Instr[5:0].
REQ-007 zero  in  1  ALU zero flag (combinational, current cycle).
REQ-008 PCen, IorD, Ori, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  out  1 each  datapath controls.
REQ-009 ALUSrcB, PCSrc  out  2 each  datapath mux selects.
REQ-010 ALUControl  out  3  ALU operation.
REQ-011 state_o  out  4  current state encoding, for debug.

Function
REQ-012 Moore FSM, 4-bit state register; encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, GPIEX 12; codes 13-15 go to FETCH next cycle, all writes 0.
REQ-013 Mux encoding: IorD 0=PC/1=ALU_o; RegDst 0=rt/1=rd; MemtoReg 0=ALU_o/1=memory data; ALUSrcA 0=PC/1=A; ALUSrcB 00=B, 01=4, 10=SignExt, 11=SignExt<<2; PCSrc 00=ALUResult, 01=ALU_o, 10=jump target.
REQ-014 ALUControl: add 3'b010, sub 3'b110, and 3'b000, or 3'b001, slt 3'b111.
REQ-015 Unlisted outputs in a state are 0; ALUControl defaults to add.
REQ-016 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, PCWrite=1; next DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11 (branch target precomputed into ALU_o).
REQ-018 DECODE next: op 6'h23/6'h2B -> MEMADR; 6'h00 -> EXEC; 6'h04 (and 6'h05 if BNE_EN) -> BRANCH; 6'h08/6'h0A -> IMMEX; 6'h02 -> JUMP; 6'h3F -> GPIEX; others -> FETCH (no architectural write).
REQ-019 MEMADR: ALUSrcA=1, ALUSrcB=10; next MEMRD if op=6'h23, else MEMWR.
REQ-020 MEMRD: IorD=1; next MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-021 MEMWR: IorD=1, MemWrite=1; next FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl by funct: 6'h20 add, 6'h22 sub, 6'h24 and, 6'h25 or, 6'h2A slt; next ALUWB.
REQ-023 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 only for supported funct (else 0, instruction is a NOP); next FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, PCSrc=01; PCen=1 iff (op=6'h04 and zero=1) or (op=6'h05 and zero=0); next FETCH.
REQ-025 IMMEX: ALUSrcA=1, ALUSrcB=10, ALUControl add (6'h08) or slt (6'h0A); next IMMWB.
REQ-026 GPIEX: Ori=1, ALUSrcA=1, ALUSrcB=10, add (rt = rs + SignExt(GPIO_i)); next IMMWB.
REQ-027 IMMWB: RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-028 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-029 PCen = PCWrite | branch-taken term (REQ-024); combinational from state, op, zero.
REQ-030 Latency in cycles incl. FETCH: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi/slti/gpi 4, unsupported op 2.

Reset
REQ-031 reset low: state -> FETCH immediately, asynchronously; PCen, IRWrite, MemWrite, RegWrite forced 0 while reset is low.
REQ-032 First FETCH write occurs on the first rising clk edge after reset deasserts; reset mid-instruction abandons it with no further writes.

Verification
REQ-033 Release reset, op=6'h23: state_o 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-034 op=6'h00, funct=6'h22: EXEC ALUControl=3'b110; ALUWB RegDst=1, RegWrite=1. funct=6'h27: RegWrite=0 in ALUWB.
REQ-035 op=6'h04, zero=1 in BRANCH: PCen=1, PCSrc=01; zero=0: PCen=0; op=6'h05, BNE_EN=1, zero=0: PCen=1.
REQ-036 op=6'h3F: GPIEX has Ori=1, ALUSrcB=10; IMMWB has RegWrite=1, RegDst=0; op=6'h11: DECODE -> FETCH, no write enable asserted.
REQ-037 Assert reset low mid-MEMWR: state_o=0 same cycle, MemWrite=0 immediately; after release, FETCH asserts IRWrite=1, PCen=1.
